// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding operand fetch.
//
// Holds the architectural fetch PC and issues one word-aligned read to
// instruction memory at a time. The returned word is presented to operand
// fetch together with its PC. After each accept, fetching continues at
// PC+4 or at the redirect target. Accepting an instruction whose
// inst[31:27] equals HLT_OPCODE stops fetch until reset.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_req        read request valid (held until imem_ready)
//   imem_addr       read address, always word-aligned
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     read data valid (only observed while waiting)
//   imem_rdata      read data
//   inst_valid      inst/PC valid to operand fetch
//   inst, PC        fetched instruction and its address
//   of_ready        operand fetch accepts inst this cycle
//   isBranchTaken   redirect request, sampled only on accept
//   branchPC        redirect target (low two bits dropped)
//   halted          halt instruction accepted; fetch stopped
//
// State    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | just out of reset; request issued on the next edge
// S_REQ    | imem_req high, waiting for imem_ready
// S_WAIT   | request accepted, waiting for imem_rvalid
// S_VALID  | instruction presented, waiting for of_ready
// S_HALT   | halt instruction accepted; terminal until rst

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [4:0]  HLT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] PC,
    input  logic        of_ready,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    output logic        halted
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;

    // Masking keeps every bit of branchPC in use while forcing alignment.
    logic [31:0] branch_aligned;
    assign branch_aligned = branchPC & ~32'h0000_0003;

    // The fetch address is simply the fetch PC; imem_req qualifies it.
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC_ALIGNED;
            inst       <= 32'h0;
            PC         <= RESET_PC_ALIGNED;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        PC         <= fetch_pc;
                        inst_valid <= 1'b1;
                        state      <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (inst_valid && of_ready) begin
                        inst_valid <= 1'b0;
                        if (inst[31:27] == HLT_OPCODE) begin
                            // Halt wins over any redirect; fetch_pc is left as is.
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            fetch_pc <= isBranchTaken ? branch_aligned
                                                      : fetch_pc + 32'd4;
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven bench for fetch_unit with a small memory
// responder and an expected-instruction queue. A second instance built with
// RESET_PC = 32'hFFFF_FFFC covers address wrap-around.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic        of_ready = 1'b0;
    logic        isBranchTaken = 1'b0;
    logic [31:0] branchPC = 32'h0;
    logic        halted;

    logic        w_rst = 1'b1;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready = 1'b0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_of_ready = 1'b0;
    logic        w_br = 1'b0;
    logic [31:0] w_bpc = 32'h0;
    logic        w_halted;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .PC(PC), .of_ready(of_ready),
        .isBranchTaken(isBranchTaken), .branchPC(branchPC), .halted(halted)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .inst_valid(w_inst_valid), .inst(w_inst), .PC(w_pc), .of_ready(w_of_ready),
        .isBranchTaken(w_br), .branchPC(w_bpc), .halted(w_halted)
    );

    typedef struct {
        logic [31:0] addr;      // expected request address
        int          rdy_wait;  // cycles imem_ready held low
        int          rv_lat;    // cycles from acceptance to rvalid (>=1)
        int          of_wait;   // cycles of_ready held low
        logic        br;
        logic [31:0] bpc;
        logic        hlt;       // memory returns the halt word
        logic [31:0] nxt;       // expected imem_addr after accept
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
        return h ? 32'hF800_0000 : {5'b00010, a[26:0]};
    endfunction

    task automatic wait_req();
        int cnt = 0;
        while (!imem_req && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("req_seen", imem_req, 1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] d;
        logic        ok;
        exp_t        e;
        wait_req();
        chk("req_addr", imem_addr, v.addr);
        ok = 1'b1;
        for (int i = 0; i < v.rdy_wait; i++) begin
            imem_ready = 1'b0;
            tick();
            ok = ok && imem_req && (imem_addr == v.addr);
        end
        if (v.rdy_wait > 0) chk("req_hold", ok, 1);
        d = mem_word(v.addr, v.hlt);
        imem_ready = 1'b1;
        sb.push_back('{pc: v.addr, ins: d});
        tick();
        imem_ready = 1'b0;
        chk("wait_noreq", imem_req, 0);
        ok = !inst_valid;
        for (int i = 0; i < v.rv_lat - 1; i++) begin
            tick();
            ok = ok && !inst_valid && !imem_req;
        end
        chk("no_early_valid", ok, 1);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk("inst_valid", inst_valid, 1);
        ok = 1'b1;
        for (int i = 0; i < v.of_wait; i++) begin
            of_ready      = 1'b0;
            isBranchTaken = 1'b1;          // must be ignored outside accept
            branchPC      = 32'h0000_0F00;
            tick();
            ok = ok && inst_valid && (inst == d) && (PC == v.addr) && !imem_req;
        end
        if (v.of_wait > 0) chk("of_stall_stable", ok, 1);
        isBranchTaken = v.br;
        branchPC      = v.bpc;
        of_ready      = 1'b1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual 0 required 1");
        end else begin
            e = sb.pop_front();
            chk("pc", PC, e.pc);
            chk("inst", inst, e.ins);
        end
        tick();
        of_ready      = 1'b0;
        isBranchTaken = 1'b0;
        branchPC      = 32'h0;
        chk("halted", halted, v.hlt);
        chk("next_req", imem_req, !v.hlt);
        chk("next_addr", imem_addr, v.nxt);
        chk("valid_drop", inst_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst", inst, 32'h0);
        rst = 1'b0;
        chk("idle_noreq", imem_req, 0);
        tick();
        chk("first_req", imem_req, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        //          addr          rdy lat ofw br  bpc           hlt  nxt
        vecs[0] = '{32'h0000_0000, 0, 1, 0, 1'b0, 32'h0,        1'b0, 32'h0000_0004};
        vecs[1] = '{32'h0000_0004, 0, 1, 0, 1'b0, 32'h0,        1'b0, 32'h0000_0008};
        vecs[2] = '{32'h0000_0008, 5, 4, 3, 1'b0, 32'h0,        1'b0, 32'h0000_000C};
        vecs[3] = '{32'h0000_000C, 0, 1, 0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_000C};
        vecs[4] = '{32'h0000_0000, 0, 1, 1, 1'b0, 32'h0,        1'b0, 32'h0000_0004};
        vecs[5] = '{32'h0000_0004, 0, 2, 0, 1'b1, 32'h0000_0103, 1'b0, 32'h0000_0100};
        vecs[6] = '{32'h0000_0100, 2, 1, 0, 1'b0, 32'h0,        1'b0, 32'h0000_0104};
        vecs[7] = '{32'h0000_0000, 0, 1, 0, 1'b0, 32'h0,        1'b0, 32'h0000_0004};

        do_reset();
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Halted: stray rvalid ignored, no requests, nothing presented.
        ok = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        of_ready    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            ok = ok && !imem_req && !inst_valid && halted;
        end
        imem_rvalid = 1'b0;
        of_ready    = 1'b0;
        chk("halt_quiet", ok, 1);

        // Reset out of HALT clears halted and restarts at RESET_PC.
        do_reset();
        for (int i = 4; i < 7; i++) run_vec(vecs[i]);

        // Reset while a read is outstanding.
        wait_req();
        chk("abort_addr", imem_addr, 32'h0000_0104);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_req", imem_req, 0);
        chk("abort_valid", inst_valid, 0);
        chk("abort_halted", halted, 0);
        chk("abort_pc", PC, 32'h0);
        chk("abort_addr_rst", imem_addr, 32'h0);
        run_vec(vecs[7]);

        // Wrap-around instance.
        w_rst = 1'b0;
        tick();
        tick();
        chk("wrap_req", w_req, 1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_ready = 1'b1;
        tick();
        w_ready  = 1'b0;
        w_rvalid = 1'b1;
        w_rdata  = 32'h1000_0000;
        tick();
        w_rvalid = 1'b0;
        chk("wrap_valid", w_inst_valid, 1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        w_of_ready = 1'b1;
        tick();
        w_of_ready = 1'b0;
        chk("wrap_next_req", w_req, 1);
        chk("wrap_next_addr", w_addr, 32'h0);
        chk("wrap_halted", w_halted, 0);
        chk("wrap_inst", w_inst, 32'h1000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the operand-fetch stage.
- Holds the architectural PC and issues one word-aligned read at a time to instruction memory over a req/ready + rvalid handshake.
- Presents the returned instruction with its PC to operand fetch under a valid/ready handshake.
- Computes the next PC as PC+4, or takes the branch target supplied downstream; stops permanently on hlt.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
HLT_OPCODE, 5'b11111, value of inst[31:27] that halts fetch.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
imem_req  output  1  read request valid
imem_addr  output  32  read address; always word-aligned
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
inst_valid  output  1  inst/PC valid to operand fetch
inst  output  32  fetched instruction
PC  output  32  address of inst
of_ready  input  1  operand fetch accepts inst this cycle
isBranchTaken  input  1  redirect; sampled only on accept
branchPC  input  32  redirect target
halted  output  1  hlt accepted; fetch stopped

Behaviour:
- Internal register fetch_pc[31:0]; FSM states IDLE, REQ, WAIT, VALID, HALT. All state is clocked on rising clk.
- Reset (rst=1 at an edge, from any state):
  - state=IDLE, fetch_pc=RESET_PC, inst=0, PC=RESET_PC.
  - Outputs: imem_req=0, inst_valid=0, halted=0.
  - An in-flight memory read is abandoned. Instruction memory is reset on the same rst, so no stale rvalid arrives afterwards.
- IDLE: go to REQ on the next edge unconditionally. First imem_req is asserted in the 2nd cycle after rst falls.
- REQ:
  - imem_req=1 and imem_addr=fetch_pc, both stable until accepted.
  - If imem_ready=1, go to WAIT; otherwise stay in REQ.
- WAIT:
  - imem_req=0.
  - If imem_rvalid=1: inst<=imem_rdata, PC<=fetch_pc, go to VALID. Otherwise stay.
  - Read latency is unbounded; minimum is 1 cycle after acceptance.
- VALID:
  - inst_valid=1; inst and PC are held stable while of_ready=0.
  - Accept means inst_valid & of_ready.
  - On accept with inst[31:27]==HLT_OPCODE: go to HALT, set halted=1, leave fetch_pc unchanged. isBranchTaken is ignored.
  - On any other accept:
    - fetch_pc <= isBranchTaken ? {branchPC[31:2],2'b00} : fetch_pc+4.
    - Addition is mod 2^32, so 32'hFFFF_FFFC+4 = 0.
    - Go to REQ.
  - Accept-to-next-imem_req latency: 1 cycle.
- HALT: imem_req=0, inst_valid=0, halted=1. Terminal until rst.
- imem_rvalid in any state other than WAIT is ignored.
- isBranchTaken and branchPC are don't-care except in an accept cycle.
- Only one request is ever outstanding; a new request is never issued before the prior response is captured.
- imem_addr equals fetch_pc in every state; only imem_req qualifies it.
- Throughput: one instruction per 3 cycles when ready/rvalid/of_ready are single-cycle (REQ, WAIT, VALID).
- All outputs come directly from registers or state decode. There are no combinational paths from inputs to outputs.

Test Plan:
- Sequential fetch: rst 2 cycles, then imem_ready=1 always, rvalid 1 cycle after accept, of_ready=1, memory returns addr-tagged words -> imem_addr sequence 0,4,8,C; inst_valid pulses with PC=0,4,8,C and the matching inst; halted=0.
- Backpressure:
  - Hold imem_ready=0 for 5 cycles in REQ -> imem_req/imem_addr held at 0x8 throughout.
  - Delay rvalid 4 cycles -> no inst_valid until it arrives.
  - Hold of_ready=0 for 3 cycles -> inst/PC stable and no new imem_req.
- Branch: on accept of PC=0x4, drive isBranchTaken=1, branchPC=0x103 -> next imem_addr=0x100, next PC=0x100. Driving isBranchTaken=1 outside an accept cycle has no effect.
- Halt: memory returns 32'hF800_0000 at PC=0xC, accepted -> halted=1 next cycle; no further imem_req for 20 cycles; inst_valid=0.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, accept with isBranchTaken=0 -> next imem_addr=0x0.
- Reset mid-operation: assert rst while in WAIT with a read outstanding -> next cycle imem_req=0, inst_valid=0, halted=0, PC=RESET_PC; re-fetch starts at RESET_PC. Also, rst in HALT clears halted.
